// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if
//   Bundles every signal of the transaction arbiter except clock and reset.
//   It covers the requester-side descriptors and handshakes, and the side
//   that talks to a single I2C master.
//   modport master : view taken by the arbiter (drives grants and m_* controls)
//   modport slave  : view taken by the surroundings (requesters + I2C master)
//   Requester side : req, req_r_nw, req_dev_addr, req_num_addr, req_num_data,
//                    req_wr_data (in); gnt, wr_req, rd_data, rd_valid, done,
//                    err (out)
//   Master side    : m_start, m_r_nw, m_dev_addr, m_num_bytes_address,
//                    m_num_bytes_data, m_data_in, m_n_rst (out);
//                    m_ready, m_rd_req, m_out_data, m_out_ena (in)
interface i2c_txn_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_r_nw;
  logic [7*N_REQ-1:0] req_dev_addr;
  logic [8*N_REQ-1:0] req_num_addr;
  logic [8*N_REQ-1:0] req_num_data;
  logic [8*N_REQ-1:0] req_wr_data;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   wr_req;
  logic [7:0]         rd_data;
  logic [N_REQ-1:0]   rd_valid;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               m_start;
  logic               m_r_nw;
  logic [6:0]         m_dev_addr;
  logic [7:0]         m_num_bytes_address;
  logic [7:0]         m_num_bytes_data;
  logic [7:0]         m_data_in;
  logic               m_ready;
  logic               m_rd_req;
  logic [7:0]         m_out_data;
  logic               m_out_ena;
  logic               m_n_rst;

  modport master (
    input  req, req_r_nw, req_dev_addr, req_num_addr, req_num_data, req_wr_data,
    input  m_ready, m_rd_req, m_out_data, m_out_ena,
    output gnt, wr_req, rd_data, rd_valid, done, err,
    output m_start, m_r_nw, m_dev_addr, m_num_bytes_address, m_num_bytes_data,
    output m_data_in, m_n_rst
  );

  modport slave (
    output req, req_r_nw, req_dev_addr, req_num_addr, req_num_data, req_wr_data,
    output m_ready, m_rd_req, m_out_data, m_out_ena,
    input  gnt, wr_req, rd_data, rd_valid, done, err,
    input  m_start, m_r_nw, m_dev_addr, m_num_bytes_address, m_num_bytes_data,
    input  m_data_in, m_n_rst
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
//   Shares one I2C master among N_REQ requesters. Picks a winner round-robin,
//   holds its descriptor on the master for the whole transfer, and routes
//   write-byte requests and read strobes to the winner. If the master never
//   starts, or stays busy too long, the arbiter pulses m_n_rst and ends the
//   transfer with done+err.
//   Ports:
//     clk   : system clock
//     n_rst : synchronous active-low reset
//     bus   : i2c_txn_arbiter_if.master (requester and master-side signals)
module i2c_txn_arbiter #(
  parameter int          N_REQ       = 4,
  parameter int          IDX_W       = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2000000,
  parameter int          RECOVER_CYC = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  i2c_txn_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    BUSY,
    DONE,
    RECOVER
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [23:0]      tcnt;
  logic [1:0]       wcnt;
  logic [7:0]       rcnt;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Busy-time counter saturates instead of wrapping.
  function automatic logic [23:0] sat_inc(input logic [23:0] c);
    return (&c) ? c : c + 24'd1;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == N_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  // Round-robin search: first requesting index at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && bus.req[(int'(ptr) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  // Write data follows the granted requester live. The master samples it
  // well after wr_req, so a requester has time to update it.
  assign bus.m_data_in = bus.req_wr_data[8*idx +: 8];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state                   <= IDLE;
      ptr                     <= '0;
      idx                     <= '0;
      tcnt                    <= '0;
      wcnt                    <= '0;
      rcnt                    <= '0;
      bus.gnt                 <= '0;
      bus.wr_req              <= '0;
      bus.rd_data             <= '0;
      bus.rd_valid            <= '0;
      bus.done                <= '0;
      bus.err                 <= 1'b0;
      bus.m_start             <= 1'b0;
      bus.m_r_nw              <= 1'b0;
      bus.m_dev_addr          <= '0;
      bus.m_num_bytes_address <= '0;
      bus.m_num_bytes_data    <= '0;
      bus.m_n_rst             <= 1'b1;
    end else begin
      // Single-cycle strobes default low; states re-assert them as needed.
      bus.wr_req   <= '0;
      bus.rd_valid <= '0;

      case (state)
        IDLE: begin
          if (win_found && bus.m_ready) begin
            // Descriptor is captured once here and frozen until IDLE again.
            idx                     <= win_idx;
            bus.gnt                 <= onehot(win_idx);
            bus.m_start             <= 1'b1;
            bus.m_r_nw              <= bus.req_r_nw[win_idx];
            bus.m_dev_addr          <= bus.req_dev_addr[7*win_idx +: 7];
            bus.m_num_bytes_address <= bus.req_num_addr[8*win_idx +: 8];
            bus.m_num_bytes_data    <= bus.req_num_data[8*win_idx +: 8];
            state                   <= LAUNCH;
          end
        end

        LAUNCH: begin
          bus.m_start <= 1'b0;
          wcnt        <= '0;
          state       <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (!bus.m_ready) begin
            tcnt  <= '0;
            state <= BUSY;
          end else if (wcnt == 2'd3) begin
            // Master never acknowledged the start: treat as a failed launch.
            rcnt        <= '0;
            bus.m_n_rst <= 1'b0;
            state       <= RECOVER;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end

        BUSY: begin
          if (bus.m_rd_req) bus.wr_req <= onehot(idx);
          if (bus.m_out_ena) begin
            bus.rd_data  <= bus.m_out_data;
            bus.rd_valid <= onehot(idx);
          end
          if (bus.m_ready) begin
            bus.done <= onehot(idx);
            bus.gnt  <= '0;
            state    <= DONE;
          end else if (tcnt == TIMEOUT_CYC - 24'd1) begin
            rcnt        <= '0;
            bus.m_n_rst <= 1'b0;
            state       <= RECOVER;
          end else begin
            tcnt <= sat_inc(tcnt);
          end
        end

        RECOVER: begin
          if (rcnt == 8'(RECOVER_CYC - 1)) begin
            bus.m_n_rst <= 1'b1;
            bus.done    <= onehot(idx);
            bus.err     <= 1'b1;
            bus.gnt     <= '0;
            state       <= DONE;
          end else begin
            rcnt <= rcnt + 8'd1;
          end
        end

        // Completion strobe cycle, shared by normal and aborted transfers.
        DONE: begin
          bus.done <= '0;
          bus.err  <= 1'b0;
          ptr      <= next_idx(idx);
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;

  logic clk = 1'b0;
  logic n_rst;
  int   n_err = 0;
  int   n_chk = 0;
  int   cyc;
  int   low;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.N_REQ(4)) bus ();

  i2c_txn_arbiter #(
    .N_REQ(4),
    .IDX_W(2),
    .TIMEOUT_CYC(24'd100),
    .RECOVER_CYC(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r_nw, input logic [6:0] addr,
                         input logic [7:0] na, input logic [7:0] nd);
    bus.req_r_nw[i]          = r_nw;
    bus.req_dev_addr[7*i +: 7] = addr;
    bus.req_num_addr[8*i +: 8] = na;
    bus.req_num_data[8*i +: 8] = nd;
  endtask

  // One normal transfer; the arbiter must be in IDLE with req already set.
  task automatic do_txn(input logic [3:0] exp_gnt, input string tag);
    tick();
    chk({tag, "_gnt"}, bus.gnt, exp_gnt);
    chk({tag, "_start"}, bus.m_start, 1);
    bus.m_ready = 1'b0;
    tick();
    tick();
    bus.m_ready = 1'b1;
    tick();
    chk({tag, "_done"}, bus.done, exp_gnt);
    chk({tag, "_gnt_off"}, bus.gnt, 0);
    tick();
  endtask

  initial begin
    n_rst              = 1'b0;
    bus.req            = '0;
    bus.req_r_nw       = '0;
    bus.req_dev_addr   = '0;
    bus.req_num_addr   = '0;
    bus.req_num_data   = '0;
    bus.req_wr_data    = '0;
    bus.m_ready        = 1'b1;
    bus.m_rd_req       = 1'b0;
    bus.m_out_data     = '0;
    bus.m_out_ena      = 1'b0;
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_start", bus.m_start, 0);
    chk("rst_nrst", bus.m_n_rst, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_addr", bus.m_dev_addr, 0);
    n_rst = 1'b1;
    tick();

    // Single write from requester 1
    set_req(1, 1'b0, 7'h50, 8'd1, 8'd2);
    bus.req = 4'b0010;
    tick();
    chk("w_gnt", bus.gnt, 4'b0010);
    chk("w_start", bus.m_start, 1);
    chk("w_addr", bus.m_dev_addr, 7'h50);
    chk("w_ndata", bus.m_num_bytes_data, 2);
    chk("w_naddr", bus.m_num_bytes_address, 1);
    chk("w_rnw", bus.m_r_nw, 0);
    bus.m_ready = 1'b0;
    tick();
    chk("w_start_off", bus.m_start, 0);
    chk("w_gnt_hold", bus.gnt, 4'b0010);
    tick();
    bus.m_rd_req = 1'b1;
    tick();
    bus.m_rd_req = 1'b0;
    chk("w_wr_req", bus.wr_req, 4'b0010);
    tick();
    chk("w_wr_req_off", bus.wr_req, 0);
    bus.req_wr_data[15:8] = 8'h11;
    #1;
    chk("w_data_in", bus.m_data_in, 8'h11);
    bus.m_ready = 1'b1;
    tick();
    chk("w_done", bus.done, 4'b0010);
    chk("w_gnt_off", bus.gnt, 0);
    chk("w_err", bus.err, 0);
    bus.req = '0;
    tick();
    chk("w_done_off", bus.done, 0);

    // Round robin from pointer 0
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    bus.req = 4'b1011;
    do_txn(4'b0001, "rr0");
    do_txn(4'b0010, "rr1");
    do_txn(4'b1000, "rr3");
    do_txn(4'b0001, "rr0w");
    bus.req = '0;
    tick();

    // Read forwarding to requester 2
    set_req(2, 1'b1, 7'h2A, 8'd1, 8'd2);
    bus.req = 4'b0100;
    tick();
    chk("r_gnt", bus.gnt, 4'b0100);
    chk("r_rnw", bus.m_r_nw, 1);
    bus.m_ready = 1'b0;
    tick();
    tick();
    bus.m_out_data = 8'hA5;
    bus.m_out_ena  = 1'b1;
    tick();
    bus.m_out_ena = 1'b0;
    chk("r_valid1", bus.rd_valid, 4'b0100);
    chk("r_data1", bus.rd_data, 8'hA5);
    tick();
    chk("r_valid_off", bus.rd_valid, 0);
    bus.m_out_data = 8'h3C;
    bus.m_out_ena  = 1'b1;
    tick();
    bus.m_out_ena = 1'b0;
    chk("r_valid2", bus.rd_valid, 4'b0100);
    chk("r_data2", bus.rd_data, 8'h3C);
    bus.m_ready = 1'b1;
    tick();
    chk("r_done", bus.done, 4'b0100);
    bus.req = '0;
    tick();
    bus.m_out_data = 8'hFF;
    bus.m_out_ena  = 1'b1;
    tick();
    bus.m_out_ena = 1'b0;
    chk("r_idle_valid", bus.rd_valid, 0);
    chk("r_idle_data", bus.rd_data, 8'h3C);

    // Hang: master stays busy past the timeout
    set_req(0, 1'b0, 7'h11, 8'd1, 8'd1);
    bus.req = 4'b0001;
    tick();
    chk("h_gnt", bus.gnt, 4'b0001);
    bus.m_ready = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.m_n_rst !== 1'b0 && cyc < 300);
    chk("h_to_cycles", cyc, 102);
    low = 1;
    while (bus.m_n_rst === 1'b0 && low < 20) begin
      tick();
      if (bus.m_n_rst === 1'b0) low++;
    end
    chk("h_low_len", low, 4);
    chk("h_done", bus.done, 4'b0001);
    chk("h_err", bus.err, 1);
    chk("h_gnt_off", bus.gnt, 0);
    bus.req     = '0;
    bus.m_ready = 1'b1;
    tick();
    chk("h_done_off", bus.done, 0);
    chk("h_err_off", bus.err, 0);

    // Launch failure: master never leaves ready
    bus.req = 4'b1000;
    tick();
    chk("l_gnt", bus.gnt, 4'b1000);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.m_n_rst !== 1'b0 && cyc < 50);
    chk("l_cycles", cyc, 5);
    low = 1;
    while (bus.m_n_rst === 1'b0 && low < 20) begin
      tick();
      if (bus.m_n_rst === 1'b0) low++;
    end
    chk("l_low_len", low, 4);
    chk("l_done", bus.done, 4'b1000);
    chk("l_err", bus.err, 1);
    bus.req = '0;
    tick();

    // Descriptor freeze, then reset mid-transfer
    bus.req = 4'b0010;
    tick();
    chk("f_gnt", bus.gnt, 4'b0010);
    bus.m_ready = 1'b0;
    tick();
    tick();
    bus.req_dev_addr[13:7] = 7'h33;
    tick();
    chk("f_addr_frozen", bus.m_dev_addr, 7'h50);
    n_rst = 1'b0;
    tick();
    chk("f_rst_gnt", bus.gnt, 0);
    chk("f_rst_start", bus.m_start, 0);
    chk("f_rst_addr", bus.m_dev_addr, 0);
    chk("f_rst_nrst", bus.m_n_rst, 1);
    chk("f_rst_done", bus.done, 0);
    n_rst       = 1'b1;
    bus.m_ready = 1'b1;
    bus.req     = 4'b1010;
    tick();
    chk("f_ptr_reset", bus.gnt, 4'b0010);
    chk("f_new_addr", bus.m_dev_addr, 7'h33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
